// File: rtl/mem_commit_pkg.sv
// Shared encodings for the MEM commit stage: memory op codes, exception
// codes, FSM state encoding and small op-classification helpers.
package mem_commit_pkg;

  localparam logic [3:0] OP_NONE = 4'd0;
  localparam logic [3:0] OP_LB   = 4'd1;
  localparam logic [3:0] OP_LBU  = 4'd2;
  localparam logic [3:0] OP_LH   = 4'd3;
  localparam logic [3:0] OP_LHU  = 4'd4;
  localparam logic [3:0] OP_LW   = 4'd5;
  localparam logic [3:0] OP_SB   = 4'd6;
  localparam logic [3:0] OP_SH   = 4'd7;
  localparam logic [3:0] OP_SW   = 4'd8;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  function automatic logic op_is_load(input logic [3:0] op);
    return (op >= OP_LB) && (op <= OP_LW);
  endfunction

  function automatic logic op_is_store(input logic [3:0] op);
    return (op >= OP_SB) && (op <= OP_SW);
  endfunction

  function automatic logic op_is_half(input logic [3:0] op);
    return (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
  endfunction

  function automatic logic op_is_word(input logic [3:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mem_commit_stage_align.sv
// Byte-lane helper: extracts and extends load data from a memory word, and
// builds byte enables / lane-shifted data for stores. Sub-word offsets are
// forced to natural alignment so a misaligned access (when not trapped)
// behaves as the aligned access containing it.
module mem_load_align
  import mem_commit_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [3:0]                     op,
  input  logic [$clog2(DATA_W/8)-1:0]    off,
  input  logic [DATA_W-1:0]              rdata,
  input  logic [DATA_W-1:0]              wdata,
  output logic [DATA_W-1:0]              load_val,
  output logic [DATA_W/8-1:0]            be,
  output logic [DATA_W-1:0]              wdata_sh
);

  localparam int BE_W  = DATA_W / 8;
  localparam int OFF_W = $clog2(BE_W);

  logic [OFF_W-1:0]  eff_s;
  logic [DATA_W-1:0] lane_s;

  // Natural-alignment mask of the byte offset
  always_comb begin
    eff_s = off;
    if (op_is_half(op)) begin
      eff_s[0] = 1'b0;
    end else if (op_is_word(op)) begin
      eff_s = {OFF_W{1'b0}};
    end else begin
      eff_s = off;
    end
  end

  assign lane_s = rdata >> {eff_s, 3'b000};

  // Load extraction with sign/zero extension
  always_comb begin
    case (op)
      OP_LB:   load_val = {{(DATA_W-8){lane_s[7]}}, lane_s[7:0]};
      OP_LBU:  load_val = {{(DATA_W-8){1'b0}}, lane_s[7:0]};
      OP_LH:   load_val = {{(DATA_W-16){lane_s[15]}}, lane_s[15:0]};
      OP_LHU:  load_val = {{(DATA_W-16){1'b0}}, lane_s[15:0]};
      OP_LW:   load_val = rdata;
      default: load_val = {DATA_W{1'b0}};
    endcase
  end

  // Store byte enables and lane placement
  always_comb begin
    case (op)
      OP_SB: begin
        be       = {{(BE_W-1){1'b0}}, 1'b1} << eff_s;
        wdata_sh = {{(DATA_W-8){1'b0}}, wdata[7:0]} << {eff_s, 3'b000};
      end
      OP_SH: begin
        be       = {{(BE_W-2){1'b0}}, 2'b11} << eff_s;
        wdata_sh = {{(DATA_W-16){1'b0}}, wdata[15:0]} << {eff_s, 3'b000};
      end
      OP_SW: begin
        be       = {BE_W{1'b1}};
        wdata_sh = wdata;
      end
      OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW: begin
        be       = {BE_W{1'b1}};
        wdata_sh = {DATA_W{1'b0}};
      end
      default: begin
        be       = {BE_W{1'b0}};
        wdata_sh = {DATA_W{1'b0}};
      end
    endcase
  end

endmodule

// File: rtl/mem_commit_stage.sv
// MEM-stage successor: data-memory handshake, load extraction, exception and
// interrupt prioritisation, registered WB bundle and one-cycle flush.
// Optional macro MEM_COMMIT_ALIGN_CHK_EN: when defined, misaligned half/word
// accesses raise AdEL/AdES; when undefined they are forced to natural
// alignment and proceed.
module mem_commit_stage
  import mem_commit_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int NUM_INT = 8,
  parameter int EXC_SRC = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_pc,
  input  logic                  in_bd,
  input  logic                  in_rf_wren,
  input  logic [4:0]            in_rf_waddr,
  input  logic [DATA_W-1:0]     in_rf_wval,
  input  logic [3:0]            in_mem_op,
  input  logic [31:0]           in_addr,
  input  logic [DATA_W-1:0]     in_wdata,
  input  logic [EXC_SRC-1:0]    in_exc_vec,
  input  logic [5*EXC_SRC-1:0]  in_exc_code,
  input  logic [31:0]           in_exc_badvaddr,
  input  logic                  cp0_status_ie,
  input  logic                  cp0_status_exl,
  input  logic [NUM_INT-1:0]    cp0_status_im,
  input  logic [NUM_INT-1:0]    cp0_cause_ip,
  output logic                  dmem_req,
  output logic                  dmem_wr,
  output logic [31:0]           dmem_addr,
  output logic [DATA_W/8-1:0]   dmem_be,
  output logic [DATA_W-1:0]     dmem_wdata,
  input  logic                  dmem_gnt,
  input  logic                  dmem_rvalid,
  input  logic [DATA_W-1:0]     dmem_rdata,
  output logic                  flush,
  output logic                  wb_valid,
  output logic [31:0]           wb_pc,
  output logic                  wb_rf_wren,
  output logic [4:0]            wb_rf_waddr,
  output logic [DATA_W-1:0]     wb_rf_wval,
  output logic                  wb_exc,
  output logic                  wb_exc_int,
  output logic [4:0]            wb_exc_code,
  output logic [31:0]           wb_exc_epc,
  output logic                  wb_exc_bd,
  output logic [31:0]           wb_exc_badvaddr,
  output logic                  wb_exc_badvaddr_wren
);

  localparam int BE_W  = DATA_W / 8;
  localparam int OFF_W = $clog2(BE_W);

  state_t state_q, state_d;

  // Instruction latched for the duration of a memory access
  logic [31:0]       pc_q, pc_d;
  logic              rf_wren_q, rf_wren_d;
  logic [4:0]        rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wval_q, rf_wval_d;
  logic [3:0]        op_q, op_d;
  logic [OFF_W-1:0]  off_q, off_d;

  logic              dmem_req_q, dmem_req_d, dmem_wr_q, dmem_wr_d;
  logic [31:0]       dmem_addr_q, dmem_addr_d;
  logic [BE_W-1:0]   dmem_be_q, dmem_be_d;
  logic [DATA_W-1:0] dmem_wdata_q, dmem_wdata_d;

  logic              wb_valid_q, wb_valid_d, flush_q, flush_d;
  logic [31:0]       wb_pc_q, wb_pc_d, wb_epc_q, wb_epc_d, wb_bva_q, wb_bva_d;
  logic              wb_rf_wren_q, wb_rf_wren_d, wb_exc_q, wb_exc_d;
  logic              wb_int_q, wb_int_d, wb_bd_q, wb_bd_d, wb_bvaw_q, wb_bvaw_d;
  logic [4:0]        wb_rf_waddr_q, wb_rf_waddr_d, wb_code_q, wb_code_d;
  logic [DATA_W-1:0] wb_rf_wval_q, wb_rf_wval_d;

  logic              accept_s, is_mem_s, int_s, up_hit_s, misalign_s, exc_s;
  logic              bva_wren_s, norm_s;
  logic [4:0]        up_code_s, align_code_s, exc_code_s;
  logic [DATA_W-1:0] norm_val_s;
  logic [3:0]        al_op_s;
  logic [OFF_W-1:0]  al_off_s;
  logic [DATA_W-1:0] al_load_s, al_wdata_s;
  logic [BE_W-1:0]   al_be_s;

  assign in_ready = (state_q == ST_IDLE) & ~reset;
  assign accept_s = in_valid & in_ready;
  assign is_mem_s = op_is_load(in_mem_op) | op_is_store(in_mem_op);

  // Interrupt qualification and upstream exception priority (lowest index wins)
  always_comb begin
    int_s    = cp0_status_ie & ~cp0_status_exl & (|(cp0_status_im & cp0_cause_ip));
    up_hit_s = |in_exc_vec;
    up_code_s = 5'd0;
    for (int i = EXC_SRC - 1; i >= 0; i--) begin
      up_code_s = in_exc_vec[i] ? in_exc_code[5*i +: 5] : up_code_s;
    end
  end

`ifdef MEM_COMMIT_ALIGN_CHK_EN
  // Alignment fault detection for half/word accesses
  always_comb begin
    if (op_is_half(in_mem_op)) begin
      misalign_s = in_addr[0];
    end else if (op_is_word(in_mem_op)) begin
      misalign_s = |in_addr[OFF_W-1:0];
    end else begin
      misalign_s = 1'b0;
    end
    align_code_s = op_is_store(in_mem_op) ? EXC_ADES : EXC_ADEL;
  end
`else
  assign misalign_s   = 1'b0;
  assign align_code_s = EXC_ADEL;
`endif

  assign exc_s      = int_s | up_hit_s | misalign_s;
  assign exc_code_s = int_s ? EXC_INT : (up_hit_s ? up_code_s : align_code_s);
  assign bva_wren_s = ~int_s & (up_hit_s ? in_exc_vec[0] : misalign_s);

  // Lane helper sees the incoming op while idle, the latched op during an access
  assign al_op_s  = (state_q == ST_IDLE) ? in_mem_op : op_q;
  assign al_off_s = (state_q == ST_IDLE) ? in_addr[OFF_W-1:0] : off_q;

  mem_load_align #(.DATA_W(DATA_W)) u_align (
    .op       (al_op_s),
    .off      (al_off_s),
    .rdata    (dmem_rdata),
    .wdata    (in_wdata),
    .load_val (al_load_s),
    .be       (al_be_s),
    .wdata_sh (al_wdata_s)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    case (state_q)
      ST_IDLE: begin
        if (accept_s && !exc_s && is_mem_s) state_d = ST_REQ;
        else                                state_d = ST_IDLE;
      end
      ST_REQ: begin
        if (dmem_gnt) state_d = op_is_store(op_q) ? ST_IDLE : ST_WAIT;
        else          state_d = ST_REQ;
      end
      ST_WAIT: begin
        if (dmem_rvalid) state_d = ST_IDLE;
        else             state_d = ST_WAIT;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Non-exception commit condition and the value it writes back
  always_comb begin
    case (state_q)
      ST_IDLE: begin
        norm_s     = accept_s & ~exc_s & ~is_mem_s;
        norm_val_s = in_rf_wval;
      end
      ST_REQ: begin
        norm_s     = dmem_gnt & op_is_store(op_q);
        norm_val_s = rf_wval_q;
      end
      ST_WAIT: begin
        norm_s     = dmem_rvalid;
        norm_val_s = al_load_s;
      end
      default: begin
        norm_s     = 1'b0;
        norm_val_s = {DATA_W{1'b0}};
      end
    endcase
  end

  // FSM outputs: memory request, latched instruction and WB record
  always_comb begin
    pc_d = pc_q; rf_wren_d = rf_wren_q; rf_waddr_d = rf_waddr_q;
    rf_wval_d = rf_wval_q; op_d = op_q; off_d = off_q;
    dmem_req_d = dmem_req_q; dmem_wr_d = dmem_wr_q; dmem_addr_d = dmem_addr_q;
    dmem_be_d = dmem_be_q; dmem_wdata_d = dmem_wdata_q;
    wb_valid_d = 1'b0; flush_d = 1'b0;
    wb_pc_d = wb_pc_q; wb_rf_wren_d = wb_rf_wren_q; wb_rf_waddr_d = wb_rf_waddr_q;
    wb_rf_wval_d = wb_rf_wval_q; wb_exc_d = wb_exc_q; wb_int_d = wb_int_q;
    wb_code_d = wb_code_q; wb_epc_d = wb_epc_q; wb_bd_d = wb_bd_q;
    wb_bva_d = wb_bva_q; wb_bvaw_d = wb_bvaw_q;

    if (norm_s) begin
      wb_valid_d    = 1'b1;
      wb_pc_d       = (state_q == ST_IDLE) ? in_pc : pc_q;
      wb_rf_wren_d  = (state_q == ST_IDLE) ? in_rf_wren : rf_wren_q;
      wb_rf_waddr_d = (state_q == ST_IDLE) ? in_rf_waddr : rf_waddr_q;
      wb_rf_wval_d  = norm_val_s;
      wb_exc_d = 1'b0; wb_int_d = 1'b0; wb_code_d = 5'd0;
      wb_epc_d = 32'd0; wb_bd_d = 1'b0; wb_bva_d = 32'd0; wb_bvaw_d = 1'b0;
    end else if (accept_s && exc_s) begin
      wb_valid_d    = 1'b1;
      flush_d       = 1'b1;
      wb_pc_d       = in_pc;
      wb_rf_wren_d  = 1'b0;
      wb_rf_waddr_d = in_rf_waddr;
      wb_rf_wval_d  = {DATA_W{1'b0}};
      wb_exc_d      = 1'b1;
      wb_int_d      = int_s;
      wb_code_d     = exc_code_s;
      wb_epc_d      = in_bd ? (in_pc - 32'd4) : in_pc;
      wb_bd_d       = in_bd;
      wb_bvaw_d     = bva_wren_s;
      wb_bva_d      = bva_wren_s ? (up_hit_s ? in_exc_badvaddr : in_addr) : 32'd0;
    end else if (accept_s) begin
      pc_d = in_pc; rf_wren_d = in_rf_wren; rf_waddr_d = in_rf_waddr;
      rf_wval_d = in_rf_wval; op_d = in_mem_op; off_d = in_addr[OFF_W-1:0];
      dmem_req_d   = 1'b1;
      dmem_wr_d    = op_is_store(in_mem_op);
      dmem_addr_d  = {in_addr[31:OFF_W], {OFF_W{1'b0}}};
      dmem_be_d    = al_be_s;
      dmem_wdata_d = al_wdata_s;
    end else begin
      wb_valid_d = 1'b0;
    end

    if (state_q == ST_REQ && dmem_gnt) begin
      dmem_req_d = 1'b0;
    end else begin
      dmem_req_d = dmem_req_d;
    end
  end

  // Datapath and WB registers
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= 32'd0; rf_wren_q <= 1'b0; rf_waddr_q <= 5'd0;
      rf_wval_q <= {DATA_W{1'b0}}; op_q <= OP_NONE; off_q <= {OFF_W{1'b0}};
      dmem_req_q <= 1'b0; dmem_wr_q <= 1'b0; dmem_addr_q <= 32'd0;
      dmem_be_q <= {BE_W{1'b0}}; dmem_wdata_q <= {DATA_W{1'b0}};
      wb_valid_q <= 1'b0; flush_q <= 1'b0; wb_pc_q <= 32'd0;
      wb_rf_wren_q <= 1'b0; wb_rf_waddr_q <= 5'd0; wb_rf_wval_q <= {DATA_W{1'b0}};
      wb_exc_q <= 1'b0; wb_int_q <= 1'b0; wb_code_q <= 5'd0; wb_epc_q <= 32'd0;
      wb_bd_q <= 1'b0; wb_bva_q <= 32'd0; wb_bvaw_q <= 1'b0;
    end else begin
      pc_q <= pc_d; rf_wren_q <= rf_wren_d; rf_waddr_q <= rf_waddr_d;
      rf_wval_q <= rf_wval_d; op_q <= op_d; off_q <= off_d;
      dmem_req_q <= dmem_req_d; dmem_wr_q <= dmem_wr_d; dmem_addr_q <= dmem_addr_d;
      dmem_be_q <= dmem_be_d; dmem_wdata_q <= dmem_wdata_d;
      wb_valid_q <= wb_valid_d; flush_q <= flush_d; wb_pc_q <= wb_pc_d;
      wb_rf_wren_q <= wb_rf_wren_d; wb_rf_waddr_q <= wb_rf_waddr_d;
      wb_rf_wval_q <= wb_rf_wval_d; wb_exc_q <= wb_exc_d; wb_int_q <= wb_int_d;
      wb_code_q <= wb_code_d; wb_epc_q <= wb_epc_d; wb_bd_q <= wb_bd_d;
      wb_bva_q <= wb_bva_d; wb_bvaw_q <= wb_bvaw_d;
    end
  end

  assign dmem_req   = dmem_req_q;
  assign dmem_wr    = dmem_wr_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_be    = dmem_be_q;
  assign dmem_wdata = dmem_wdata_q;
  assign flush       = flush_q;
  assign wb_valid    = wb_valid_q;
  assign wb_pc       = wb_pc_q;
  assign wb_rf_wren  = wb_rf_wren_q;
  assign wb_rf_waddr = wb_rf_waddr_q;
  assign wb_rf_wval  = wb_rf_wval_q;
  assign wb_exc      = wb_exc_q;
  assign wb_exc_int  = wb_int_q;
  assign wb_exc_code = wb_code_q;
  assign wb_exc_epc  = wb_epc_q;
  assign wb_exc_bd   = wb_bd_q;
  assign wb_exc_badvaddr      = wb_bva_q;
  assign wb_exc_badvaddr_wren = wb_bvaw_q;

endmodule

// File: tb/tb_mem_commit_stage.sv
// Scoreboard bench for mem_commit_stage: a driver issues directed and random
// instructions and plays the data-memory side; expected WB records come from
// a reference model and are checked by an independent monitor.
module tb_mem_commit_stage;

  logic        clk, reset, in_valid, in_ready, in_bd, in_rf_wren;
  logic [31:0] in_pc, in_rf_wval, in_addr, in_wdata, in_exc_badvaddr;
  logic [4:0]  in_rf_waddr;
  logic [3:0]  in_mem_op;
  logic [2:0]  in_exc_vec;
  logic [14:0] in_exc_code;
  logic        cp0_status_ie, cp0_status_exl;
  logic [7:0]  cp0_status_im, cp0_cause_ip;
  logic        dmem_req, dmem_wr, dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        flush, wb_valid, wb_rf_wren, wb_exc, wb_exc_int, wb_exc_bd, wb_exc_badvaddr_wren;
  logic [31:0] wb_pc, wb_rf_wval, wb_exc_epc, wb_exc_badvaddr;
  logic [4:0]  wb_rf_waddr, wb_exc_code;

  mem_commit_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_bd(in_bd), .in_rf_wren(in_rf_wren), .in_rf_waddr(in_rf_waddr),
    .in_rf_wval(in_rf_wval), .in_mem_op(in_mem_op), .in_addr(in_addr), .in_wdata(in_wdata),
    .in_exc_vec(in_exc_vec), .in_exc_code(in_exc_code), .in_exc_badvaddr(in_exc_badvaddr),
    .cp0_status_ie(cp0_status_ie), .cp0_status_exl(cp0_status_exl),
    .cp0_status_im(cp0_status_im), .cp0_cause_ip(cp0_cause_ip),
    .dmem_req(dmem_req), .dmem_wr(dmem_wr), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(dmem_rdata), .flush(flush), .wb_valid(wb_valid), .wb_pc(wb_pc),
    .wb_rf_wren(wb_rf_wren), .wb_rf_waddr(wb_rf_waddr), .wb_rf_wval(wb_rf_wval),
    .wb_exc(wb_exc), .wb_exc_int(wb_exc_int), .wb_exc_code(wb_exc_code),
    .wb_exc_epc(wb_exc_epc), .wb_exc_bd(wb_exc_bd), .wb_exc_badvaddr(wb_exc_badvaddr),
    .wb_exc_badvaddr_wren(wb_exc_badvaddr_wren)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] pc, addr, rf_wval, wdata, badvaddr, rdata;
    logic        bd, rf_wren, ie, exl;
    logic [4:0]  waddr;
    logic [2:0]  exc_vec;
    logic [14:0] exc_code;
    logic [7:0]  im, ip;
    int          gnt_dly, rv_dly;
  } txn_t;

  typedef struct {
    logic [31:0] pc, epc, bva, rf_wval, addr_al, wdata_sh;
    logic        exc, is_int, bd, bva_wren, rf_wren, mem, wr;
    logic [4:0]  code, waddr;
    logic [3:0]  be;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, req, $time);
    end
  endtask

  // Reference model: derives the architectural outcome from the rules directly
  function automatic exp_t model(input txn_t t);
    exp_t e;
    int first, off;
    bit is_ld, is_st, half, word, mis;
    logic [31:0] lane;
    e = '{default: '0};
    e.pc = t.pc;
    e.waddr = t.waddr;
    is_ld = (t.op >= 4'd1 && t.op <= 4'd5);
    is_st = (t.op >= 4'd6 && t.op <= 4'd8);
    half  = (t.op == 4'd3 || t.op == 4'd4 || t.op == 4'd7);
    word  = (t.op == 4'd5 || t.op == 4'd8);
    mis   = (half && (t.addr % 2 != 0)) || (word && (t.addr % 4 != 0));
    first = -1;
    for (int i = 2; i >= 0; i--) if (t.exc_vec[i]) first = i;
    if (t.ie && !t.exl && ((t.im & t.ip) != 8'd0)) begin
      e.exc = 1'b1; e.is_int = 1'b1; e.code = 5'd0;
    end else if (first >= 0) begin
      e.exc = 1'b1;
      e.code = t.exc_code[5*first +: 5];
      e.bva_wren = (first == 0);
      e.bva = t.badvaddr;
`ifdef MEM_COMMIT_ALIGN_CHK_EN
    end else if (mis) begin
      e.exc = 1'b1; e.code = is_st ? 5'd5 : 5'd4;
      e.bva_wren = 1'b1; e.bva = t.addr;
`endif
    end else begin
      e.rf_wren = t.rf_wren;
      e.mem = is_ld || is_st;
      e.wr = is_st;
      e.addr_al = t.addr & 32'hFFFF_FFFC;
      off = int'(t.addr % 4);
      if (half) off = off & 2;
      if (word) off = 0;
      lane = t.rdata >> (8 * off);
      case (t.op)
        4'd1: e.rf_wval = lane[7] ? ((lane & 32'hFF) | 32'hFFFF_FF00) : (lane & 32'hFF);
        4'd2: e.rf_wval = lane & 32'hFF;
        4'd3: e.rf_wval = lane[15] ? ((lane & 32'hFFFF) | 32'hFFFF_0000) : (lane & 32'hFFFF);
        4'd4: e.rf_wval = lane & 32'hFFFF;
        4'd5: e.rf_wval = t.rdata;
        default: e.rf_wval = t.rf_wval;
      endcase
      case (t.op)
        4'd6: begin e.be = 4'(1 << off); e.wdata_sh = (t.wdata & 32'hFF) << (8 * off); end
        4'd7: begin e.be = 4'(3 << off); e.wdata_sh = (t.wdata & 32'hFFFF) << (8 * off); end
        default: begin e.be = 4'hF; e.wdata_sh = t.wdata; end
      endcase
    end
    if (e.exc) begin
      e.epc = t.bd ? (t.pc - 32'd4) : t.pc;
      e.bd = t.bd;
    end
    return e;
  endfunction

  task automatic scramble_inputs();
    in_pc = $urandom; in_addr = $urandom; in_wdata = $urandom; in_rf_wval = $urandom;
    in_rf_waddr = 5'($urandom); in_mem_op = 4'($urandom_range(0, 8)); in_bd = 1'($urandom);
    in_rf_wren = 1'($urandom); in_exc_vec = 3'($urandom); in_exc_code = 15'($urandom);
    in_exc_badvaddr = $urandom; cp0_status_ie = 1'($urandom); cp0_status_exl = 1'($urandom);
    cp0_status_im = 8'($urandom); cp0_cause_ip = 8'($urandom);
  endtask

  task automatic run_txn(input txn_t t);
    exp_t e;
    int n;
    e = model(t);
    n = 0;
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    check("ready_before_issue", in_ready, 1'b1);
    in_pc = t.pc; in_bd = t.bd; in_rf_wren = t.rf_wren; in_rf_waddr = t.waddr;
    in_rf_wval = t.rf_wval; in_mem_op = t.op; in_addr = t.addr; in_wdata = t.wdata;
    in_exc_vec = t.exc_vec; in_exc_code = t.exc_code; in_exc_badvaddr = t.badvaddr;
    cp0_status_ie = t.ie; cp0_status_exl = t.exl; cp0_status_im = t.im; cp0_cause_ip = t.ip;
    in_valid = 1'b1;
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    scramble_inputs();
    if (!e.mem) begin
      check("commit_latency_direct", wb_valid, 1'b1);
      check("no_req_direct", dmem_req, 1'b0);
    end else begin
      for (int k = 0; k <= t.gnt_dly; k++) begin
        check("req_held", dmem_req, 1'b1);
        check("ready_low_req", in_ready, 1'b0);
        check("no_early_wb", wb_valid, 1'b0);
        check("req_addr", dmem_addr, e.addr_al);
        check("req_wr", dmem_wr, e.wr);
        if (e.wr) begin
          check("req_be", dmem_be, e.be);
          check("req_wdata", dmem_wdata, e.wdata_sh);
        end
        dmem_gnt = (k == t.gnt_dly);
        dmem_rvalid = 1'($urandom);
        dmem_rdata = $urandom;
        @(posedge clk);
        @(negedge clk);
      end
      dmem_gnt = 1'b0;
      dmem_rvalid = 1'b0;
      if (e.wr) begin
        check("store_commit_latency", wb_valid, 1'b1);
        check("req_drop_store", dmem_req, 1'b0);
      end else begin
        for (int k = 0; k <= t.rv_dly; k++) begin
          check("req_drop_load", dmem_req, 1'b0);
          check("ready_low_wait", in_ready, 1'b0);
          check("no_early_wb_wait", wb_valid, 1'b0);
          dmem_rvalid = (k == t.rv_dly);
          dmem_rdata = (k == t.rv_dly) ? t.rdata : $urandom;
          @(posedge clk);
          @(negedge clk);
        end
        dmem_rvalid = 1'b0;
        check("load_commit_latency", wb_valid, 1'b1);
      end
    end
  endtask

  function automatic txn_t base_txn();
    txn_t t;
    t = '{default: '0};
    t.pc = 32'h0000_0400;
    t.rf_wval = 32'hA5A5_0001;
    t.waddr = 5'd3;
    t.rf_wren = 1'b1;
    t.exc_code = 15'h7FFF;
    return t;
  endfunction

  // Monitor: pops the scoreboard whenever the DUT presents a WB record
  always @(negedge clk) begin
    if (!reset) begin
      if (wb_valid) begin
        if (sb_q.size() == 0) begin
          check("unexpected_wb", wb_valid, 1'b0);
        end else begin
          mon_e = sb_q.pop_front();
          check("wb_pc", wb_pc, mon_e.pc);
          check("wb_exc", wb_exc, mon_e.exc);
          check("flush", flush, mon_e.exc);
          check("wb_exc_int", wb_exc_int, mon_e.is_int);
          check("wb_rf_wren", wb_rf_wren, mon_e.rf_wren);
          check("wb_rf_wval", wb_rf_wval, mon_e.exc ? 32'd0 : mon_e.rf_wval);
          check("wb_bva_wren", wb_exc_badvaddr_wren, mon_e.bva_wren);
          if (mon_e.exc) begin
            check("wb_exc_code", wb_exc_code, mon_e.code);
            check("wb_exc_epc", wb_exc_epc, mon_e.epc);
            check("wb_exc_bd", wb_exc_bd, mon_e.bd);
          end else begin
            check("wb_rf_waddr", wb_rf_waddr, mon_e.waddr);
          end
          if (mon_e.bva_wren) check("wb_badvaddr", wb_exc_badvaddr, mon_e.bva);
        end
      end else if (flush) begin
        check("flush_without_wb", flush, 1'b0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    txn_t t;
    reset = 1'b1; in_valid = 1'b0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'd0;
    scramble_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_dmem_req", dmem_req, 1'b0);
    check("rst_dmem_wr", dmem_wr, 1'b0);
    check("rst_dmem_addr", dmem_addr, 32'd0);
    check("rst_dmem_be", dmem_be, 4'd0);
    check("rst_dmem_wdata", dmem_wdata, 32'd0);
    check("rst_flush", flush, 1'b0);
    check("rst_wb_valid", wb_valid, 1'b0);
    check("rst_wb_pc", wb_pc, 32'd0);
    check("rst_wb_rf_wval", wb_rf_wval, 32'd0);
    check("rst_wb_exc", wb_exc, 1'b0);
    check("rst_wb_epc", wb_exc_epc, 32'd0);
    check("rst_in_ready", in_ready, 1'b0);
    reset = 1'b0;
    #1;
    check("ready_after_reset", in_ready, 1'b1);
    @(negedge clk);

    t = base_txn(); t.op = 4'd5; t.addr = 32'h1000; t.gnt_dly = 2; t.rdata = 32'hDEAD_BEEF;
    run_txn(t);
    t = base_txn(); t.op = 4'd1; t.addr = 32'h1003; t.rdata = 32'h80FF_FF7F; t.gnt_dly = 1;
    run_txn(t);
    t.op = 4'd2;
    run_txn(t);
    t = base_txn(); t.op = 4'd7; t.addr = 32'h2002; t.wdata = 32'h0000_1234; t.gnt_dly = 1;
    t.rf_wren = 1'b0;
    run_txn(t);
    t = base_txn(); t.op = 4'd5; t.addr = 32'h1001; t.rdata = 32'h1122_3344; t.rv_dly = 2;
    run_txn(t);
    t = base_txn(); t.op = 4'd5; t.addr = 32'h4000; t.pc = 32'h80; t.bd = 1'b1;
    t.ie = 1'b1; t.im = 8'h04; t.ip = 8'h04;
    run_txn(t);
    t.exc_vec = 3'b010;
    run_txn(t);
    t = base_txn(); t.exc_vec = 3'b101; t.badvaddr = 32'hBAD0_0004; t.exc_code = 15'h1234;
    run_txn(t);
    t.exc_vec = 3'b110;
    run_txn(t);
    t = base_txn(); t.ie = 1'b1; t.exl = 1'b1; t.im = 8'h04; t.ip = 8'h04;
    run_txn(t);

    // Reset while waiting for load data
    @(negedge clk);
    in_pc = 32'h500; in_mem_op = 4'd5; in_addr = 32'h3000; in_exc_vec = 3'b000;
    cp0_status_ie = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; dmem_gnt = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dmem_gnt = 1'b0; reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_wait_req", dmem_req, 1'b0);
    check("rst_wait_wb_valid", wb_valid, 1'b0);
    reset = 1'b0;
    #1;
    check("rst_wait_ready", in_ready, 1'b1);
    @(negedge clk);
    dmem_rvalid = 1'b1; dmem_rdata = 32'hFFFF_0000;
    @(posedge clk);
    @(negedge clk);
    dmem_rvalid = 1'b0;
    check("stale_rvalid_ignored", wb_valid, 1'b0);

    for (int i = 0; i < 200; i++) begin
      t = base_txn();
      t.op = 4'($urandom_range(0, 8));
      t.addr = $urandom;
      if ($urandom_range(0, 1) == 0) t.addr = t.addr & 32'hFFFF_FFFC;
      t.pc = $urandom & 32'hFFFF_FFFC;
      t.bd = 1'($urandom);
      t.rf_wren = 1'($urandom);
      t.waddr = 5'($urandom);
      t.rf_wval = $urandom;
      t.wdata = $urandom;
      t.rdata = $urandom;
      t.badvaddr = $urandom;
      t.exc_code = 15'($urandom);
      t.exc_vec = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      t.ie = 1'($urandom);
      t.exl = ($urandom_range(0, 3) == 0);
      t.im = 8'($urandom);
      t.ip = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      t.gnt_dly = $urandom_range(0, 3);
      t.rv_dly = $urandom_range(0, 3);
      run_txn(t);
    end

    repeat (4) @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_commit_stage.md
Name: mem_commit_stage

Overview:
- Parametrised MEM-stage successor. Sits between EXE/MEM pipeline register and WB.
- Owns the data-memory request/grant/response handshake (multi-cycle), load byte/half extraction, alignment exceptions and exception/interrupt prioritisation over NUM_INT interrupt lines.
- Produces the registered WB bundle plus a one-cycle pipeline flush.

Parameters:
- DATA_W, 32, datapath and memory word width (multiple of 16).
- NUM_INT, 8, interrupt lines (status.IM / cause.IP width).
- EXC_SRC, 3, upstream exception sources; index 0 = IF (highest priority, carries badvaddr).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- in_valid  in  1  MEM-stage instruction present
- in_ready  out  1  stage can accept; high only in IDLE
- in_pc  in  32  instruction PC
- in_bd  in  1  instruction in branch delay slot
- in_rf_wren  in  1  GPR write enable
- in_rf_waddr  in  5  GPR write index
- in_rf_wval  in  DATA_W  ALU result
- in_mem_op  in  4  0 none, 1 lb, 2 lbu, 3 lh, 4 lhu, 5 lw, 6 sb, 7 sh, 8 sw
- in_addr  in  32  effective address
- in_wdata  in  DATA_W  store data, unshifted
- in_exc_vec  in  EXC_SRC  upstream exception flags
- in_exc_code  in  5*EXC_SRC  exccode per source
- in_exc_badvaddr  in  32  IF fault address
- cp0_status_ie  in  1  global interrupt enable
- cp0_status_exl  in  1  exception level
- cp0_status_im  in  NUM_INT  interrupt mask
- cp0_cause_ip  in  NUM_INT  interrupt pending
- dmem_req  out  1  request valid
- dmem_wr  out  1  1 = store
- dmem_addr  out  32  word-aligned address
- dmem_be  out  DATA_W/8  byte enables
- dmem_wdata  out  DATA_W  lane-shifted store data
- dmem_gnt  in  1  request accepted this cycle
- dmem_rvalid  in  1  load data valid
- dmem_rdata  in  DATA_W  load word
- flush  out  1  exception or interrupt taken (1-cycle pulse)
- wb_valid  out  1  WB bundle valid (1-cycle pulse)
- wb_pc, wb_rf_wren, wb_rf_waddr, wb_rf_wval  out  32/1/5/DATA_W  registered commit
- wb_exc, wb_exc_int, wb_exc_code, wb_exc_epc, wb_exc_bd, wb_exc_badvaddr, wb_exc_badvaddr_wren  out  1/1/5/32/1/32/1  registered exception record

Behaviour:
- Reset: all outputs 0; FSM to IDLE; dmem_req dropped immediately. The memory side is reset by the same reset.
- FSM states and transitions:
  - IDLE, on in_valid accept:
    - if interrupt or exception: commit same cycle (no memory access).
    - else if in_mem_op == 0: commit same cycle.
    - else: latch the instruction, go REQ.
  - REQ: dmem_req=1, outputs held stable until dmem_gnt. On gnt: a store commits next cycle and returns to IDLE; a load goes to WAIT.
  - WAIT: on dmem_rvalid, commit the extracted load value, go IDLE.
- Commit: registered, so WB outputs are valid the cycle after the commit condition.
  - Latency: non-memory op 1 cycle; store 1 + cycles to gnt; load ≥ 2 cycles after gnt.
- Interrupt: int = ie & ~exl & |(im & ip).
  - Sampled only in IDLE on an accepted instruction, never mid-access.
  - Has priority over all exceptions. wb_exc_int=1, wb_exc_code=0.
- Exception priority: in_exc_vec[0] > … > in_exc_vec[EXC_SRC-1] > alignment.
  - badvaddr_wren=1 only for source 0 (in_exc_badvaddr) or alignment (in_addr).
  - Alignment faults: lh/lhu addr[0] → code 4; lw addr[1:0]≠0 → 4; sh → 5; sw → 5.
- EPC: in_bd ? in_pc-4 : in_pc. wb_exc_bd = in_bd.
- On interrupt or exception: flush=1 for exactly the cycle the WB record is written; wb_rf_wren=0, wb_rf_wval=0.
- Store lane shift: sb uses be=1<<addr[1:0]; sh uses be=3<<addr[1:0] (addr[1] selects half).
- Load extraction: from dmem_rdata by addr[1:0]. lb/lh sign-extend; lbu/lhu zero-extend.
- Simultaneous gnt and rvalid in REQ is illegal (rvalid ignored). rvalid outside WAIT is ignored.

Optional Feature:
- MEM_COMMIT_ALIGN_CHK_EN defined: alignment exceptions as above.
- Undefined: no alignment exception. Address low bits are masked to natural alignment (halfword addr[0]=0, word addr[1:0]=0) and the access proceeds.

Decomposition:
- Package mem_commit_pkg holds:
  - mem_op encodings
  - exccodes: ADEL=4, ADES=5, INT=0
  - FSM state encoding (IDLE/REQ/WAIT)
- Sub-module mem_load_align: combinational rdata + addr[1:0] + op → extended value; also used for store be/wdata generation.

Test Plan:
- lw addr 0x1000, gnt after 2 cycles, rvalid 1 cycle later, rdata 0xDEADBEEF → wb_rf_wval 0xDEADBEEF, wb_valid once, in_ready low throughout.
- lb addr 0x1003, rdata 0x80FF_FF7F → 0xFFFFFF80; lbu → 0x00000080.
- sh addr 0x2002, wdata 0x1234 → dmem_be 4'b1100, dmem_wdata 0x12340000, wr=1; commit after gnt.
- lw addr 0x1001, ALIGN_CHK_EN defined → flush=1, code 4, badvaddr 0x1001, no dmem_req. Undefined → dmem_addr 0x1000, normal load.
- ie=1, exl=0, im=8'h04, ip=8'h04, in_bd=1, pc 0x80 → wb_exc_int=1, epc 0x7C, bd=1, rf_wren=0; with simultaneous in_exc_vec[1], interrupt still wins.
- reset asserted while in WAIT → next cycle FSM IDLE, dmem_req 0, wb_valid 0, in_ready 1.
